// File: rtl/shreg_seq_ctrl.sv
// Select sequencer for the mux4 universal shift-register array (HOLD/SHL/SHR/LOAD).
// Optional rotate support: define SHREG_ROTATE_EN to drive ser_src from cmd_rot during shifts.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a command, selects hold
// S_LOAD  | parallel-load select for one cycle
// S_SHIFT | shift select active, remaining counts down to 0
// S_DONE  | one-cycle completion pulse, selects hold, not ready
module shreg_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [CNT_W-1:0] i_cmd_cnt,
  input  logic             i_cmd_rot,
  output logic             o_sel_j1,
  output logic             o_sel_j0,
  output logic             o_ser_src,
  output logic [CNT_W-1:0] o_remaining,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [1:0]       OP_HOLD = 2'b00;
  localparam logic [1:0]       OP_LOAD = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam int               w_unused_width = WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_remaining, w_rem_nxt;
  logic             r_dir, w_dir_nxt;  // 1 = shift right
  logic             r_sel_j1, r_sel_j0, r_ser_src;
  logic             r_busy, r_done, r_cmd_ready;
  logic             w_j1_nxt, w_j0_nxt, w_ser_nxt;
  logic             w_accept;
`ifdef SHREG_ROTATE_EN
  logic             r_rot, w_rot_nxt;
`else
  logic             w_unused_rot;
  assign w_unused_rot = i_cmd_rot;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_remaining;
    w_dir_nxt   = r_dir;
`ifdef SHREG_ROTATE_EN
    w_rot_nxt   = r_rot;
`endif
    w_accept    = i_cmd_valid && r_cmd_ready;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (i_cmd_op == OP_LOAD) begin
            w_state_nxt = S_LOAD;
          end else if (i_cmd_op != OP_HOLD && i_cmd_cnt != '0) begin
            w_state_nxt = S_SHIFT;
            w_rem_nxt   = i_cmd_cnt;
            w_dir_nxt   = i_cmd_op[1];
`ifdef SHREG_ROTATE_EN
            w_rot_nxt   = i_cmd_rot;
`endif
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_LOAD:  w_state_nxt = S_DONE;
      S_SHIFT: begin
        w_rem_nxt = r_remaining - CNT_ONE;
        if (r_remaining == CNT_ONE) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    w_j1_nxt  = 1'b0;
    w_j0_nxt  = 1'b0;
    w_ser_nxt = 1'b0;
    case (w_state_nxt)
      S_LOAD: begin
        w_j1_nxt = 1'b1;
        w_j0_nxt = 1'b1;
      end
      S_SHIFT: begin
        w_j1_nxt = ~w_dir_nxt;
        w_j0_nxt = w_dir_nxt;
`ifdef SHREG_ROTATE_EN
        w_ser_nxt = w_rot_nxt;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_dir       <= 1'b0;
`ifdef SHREG_ROTATE_EN
      r_rot       <= 1'b0;
`endif
      r_sel_j1    <= 1'b0;
      r_sel_j0    <= 1'b0;
      r_ser_src   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_rem_nxt;
      r_dir       <= w_dir_nxt;
`ifdef SHREG_ROTATE_EN
      r_rot       <= w_rot_nxt;
`endif
      r_sel_j1    <= w_j1_nxt;
      r_sel_j0    <= w_j0_nxt;
      r_ser_src   <= w_ser_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      r_cmd_ready <= (w_state_nxt == S_IDLE);
    end
  end

  assign o_sel_j1    = r_sel_j1;
  assign o_sel_j0    = r_sel_j0;
  assign o_ser_src   = r_ser_src;
  assign o_remaining = r_remaining;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_cmd_ready = r_cmd_ready;

endmodule

// File: tb/tb_shreg_seq_ctrl.sv
// Self-checking bench for shreg_seq_ctrl: each command is expanded into its
// expected per-cycle output trace and compared cycle by cycle.
module tb_shreg_seq_ctrl;
  localparam int CNT_W = 4;
  localparam int EW    = 2 + CNT_W + 4;
`ifdef SHREG_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic             cmd_rot;
  logic             sel_j1, sel_j0, ser_src;
  logic [CNT_W-1:0] remaining;
  logic             busy, done;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] q_exp[$];

  always #5 clk = ~clk;

  shreg_seq_ctrl #(.WIDTH(8), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_cnt(cmd_cnt), .i_cmd_rot(cmd_rot),
    .o_sel_j1(sel_j1), .o_sel_j0(sel_j0), .o_ser_src(ser_src),
    .o_remaining(remaining), .o_busy(busy), .o_done(done)
  );

  // vector layout: {j1,j0, remaining, busy, done, ready, ser_src}
  function automatic logic [EW-1:0] obs();
    return {sel_j1, sel_j0, remaining, busy, done, cmd_ready, ser_src};
  endfunction

  function automatic logic [EW-1:0] mk(logic [1:0] sel, int rem, bit b, bit d, bit r, bit s);
    logic [CNT_W-1:0] rv;
    rv = CNT_W'(rem);
    return {sel, rv, b, d, r, s};
  endfunction

  // Expected trace from the cycle after acceptance up to and including the
  // first IDLE cycle.
  function automatic void build(logic [1:0] op, int cnt, bit rot);
    q_exp.delete();
    if (op == 2'd3) begin
      q_exp.push_back(mk(2'b11, 0, 1, 0, 0, 0));
    end else if (op != 2'd0 && cnt > 0) begin
      for (int i = cnt; i >= 1; i--)
        q_exp.push_back(mk((op == 2'd1) ? 2'b10 : 2'b01, i, 1, 0, 0, ROT && rot));
    end
    q_exp.push_back(mk(2'b00, 0, 1, 1, 0, 0));
    q_exp.push_back(mk(2'b00, 0, 0, 0, 1, 0));
  endfunction

  task automatic send(logic [1:0] op, int cnt, bit rot, bit hold_valid);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = CNT_W'(cnt);
    cmd_rot   = rot;
    @(posedge clk);
    #1;
    if (!hold_valid) begin
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_cnt   = CNT_W'($urandom);
      cmd_rot   = 1'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b01; cmd_cnt = 4'd5; cmd_rot = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    total++;
    if (obs() !== mk(2'b00, 0, 0, 0, 1, 0)) begin
      bad++;
      $display("FAIL reset: got %b want %b", obs(), mk(2'b00, 0, 0, 0, 1, 0));
    end
  endtask

  task automatic test_fixed(string name, logic [1:0] op, int cnt, bit rot);
    build(op, cnt, rot);
    send(op, cnt, rot, 1'b0);
    foreach (q_exp[i]) begin
      @(negedge clk);
      total++;
      if (obs() !== q_exp[i]) begin
        bad++;
        $display("FAIL %s cyc%0d: got %b want %b", name, i, obs(), q_exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    send(2'b10, 15, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== mk(2'b01, 15 - i, 1, 0, 0, 0)) begin
        bad++;
        $display("FAIL rst_mid shift%0d: got %b want %b", i, obs(), mk(2'b01, 15 - i, 1, 0, 0, 0));
      end
    end
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_cnt = 4'd2;
    @(posedge clk);
    #1;
    rst = 1'b0; cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== mk(2'b00, 0, 0, 0, 1, 0)) begin
        bad++;
        $display("FAIL rst_mid idle%0d: got %b want %b", i, obs(), mk(2'b00, 0, 0, 0, 1, 0));
      end
    end
    test_fixed("after_rst", 2'b01, 1, 1'b0);
  endtask

  task automatic test_rotate_busy();
    build(2'b01, 2, 1'b1);
    send(2'b01, 2, 1'b1, 1'b1);
    foreach (q_exp[i]) begin
      @(negedge clk);
      total++;
      if (obs() !== q_exp[i]) begin
        bad++;
        $display("FAIL rot_busy cyc%0d: got %b want %b", i, obs(), q_exp[i]);
      end
    end
    cmd_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (obs() !== mk(2'b00, 0, 0, 0, 1, 0)) begin
        bad++;
        $display("FAIL rot_busy no_second: got %b want %b", obs(), mk(2'b00, 0, 0, 0, 1, 0));
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    int cnt;
    bit rot;
    for (int n = 0; n < 30; n++) begin
      op  = 2'($urandom_range(0, 3));
      cnt = ($urandom_range(0, 5) == 0) ? 15 : int'($urandom_range(0, 15));
      rot = 1'($urandom);
      build(op, cnt, rot);
      send(op, cnt, rot, 1'b0);
      foreach (q_exp[i]) begin
        @(negedge clk);
        total++;
        if (obs() !== q_exp[i]) begin
          bad++;
          $display("FAIL rand%0d op%0d cnt%0d cyc%0d: got %b want %b", n, op, cnt, i, obs(), q_exp[i]);
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_fixed("shl3", 2'b01, 3, 1'b0);
    test_fixed("load", 2'b11, 0, 1'b0);
    test_fixed("shr0", 2'b10, 0, 1'b1);
    test_fixed("hold5", 2'b00, 5, 1'b0);
    test_fixed("shl15", 2'b01, 15, 1'b1);
    test_reset_mid();
    test_rotate_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
